// File: rtl/rtn_xbar_core_4x3_pkg.sv
// Shared sizes and types for the memory-port controller return path.
package mpc_types;

   localparam int BANK_NUM   = 4;
   localparam int CH_NUM     = 3;
   localparam int RSP_DATA_W = 128;
   localparam int BANK_ID_W  = 2;
   localparam int CH_ID_W    = 2;

   // channel_id value that addresses no channel; such beats are dropped
   localparam logic [CH_ID_W-1:0] CH_ID_INVALID = 2'd3;

   typedef struct packed {
      logic [RSP_DATA_W-1:0] data;
      logic [BANK_ID_W-1:0]  bank_id;
   } rtn_rsp_t;

   // Index of the set bit in a one-hot bank vector (0 when empty)
   function automatic logic [BANK_ID_W-1:0] onehot_to_idx(input logic [BANK_NUM-1:0] oh);
      logic [BANK_ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < BANK_NUM; i++) begin
         if (oh[i]) idx = BANK_ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rtn_xbar_core_4x3_rr_arb.sv
// N-way round-robin arbiter. The pointer names the highest-priority
// requester; after a grant to k it moves to k+1 so k becomes lowest.
module rr_arb #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i_req,
   input  logic         i_en,
   output logic [N-1:0] o_gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_ptr_nxt;
   logic [N-1:0]  w_gnt;
   logic          w_found;
   logic [PW-1:0] w_idx;
   int            w_idx_int;

   // Scan requesters starting at the pointer; first hit wins
   always_comb begin
      w_gnt     = '0;
      w_ptr_nxt = r_ptr;
      w_found   = 1'b0;
      w_idx_int = 0;
      w_idx     = '0;
      for (int i = 0; i < N; i++) begin
         w_idx_int = int'(r_ptr) + i;
         if (w_idx_int >= N) w_idx_int = w_idx_int - N;
         w_idx = PW'(w_idx_int);
         if (!w_found && i_en && i_req[w_idx]) begin
            w_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
            w_ptr_nxt    = (w_idx_int == N - 1) ? '0 : PW'(w_idx_int + 1);
         end
      end
   end

   // Pointer register; only advances when a grant was issued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/rtn_xbar_core_4x3.sv
// Return-path crossbar: 4 memory banks -> 3 requesting channels.
// Each channel owns a round-robin arbiter and a one-beat output slot.
module rtn_xbar_core_4x3
   import mpc_types::*;
(
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  d_bank_0_rsp_valid,
   output logic                  d_bank_0_rsp_ready,
   input  logic [RSP_DATA_W-1:0] d_bank_0_rsp_data,
   input  logic [CH_ID_W-1:0]    d_bank_0_rsp_channel_id,

   input  logic                  d_bank_1_rsp_valid,
   output logic                  d_bank_1_rsp_ready,
   input  logic [RSP_DATA_W-1:0] d_bank_1_rsp_data,
   input  logic [CH_ID_W-1:0]    d_bank_1_rsp_channel_id,

   input  logic                  d_bank_2_rsp_valid,
   output logic                  d_bank_2_rsp_ready,
   input  logic [RSP_DATA_W-1:0] d_bank_2_rsp_data,
   input  logic [CH_ID_W-1:0]    d_bank_2_rsp_channel_id,

   input  logic                  d_bank_3_rsp_valid,
   output logic                  d_bank_3_rsp_ready,
   input  logic [RSP_DATA_W-1:0] d_bank_3_rsp_data,
   input  logic [CH_ID_W-1:0]    d_bank_3_rsp_channel_id,

   output logic                  u_channel_0_rsp_valid,
   input  logic                  u_channel_0_rsp_ready,
   output logic [RSP_DATA_W-1:0] u_channel_0_rsp_data,
   output logic [BANK_ID_W-1:0]  u_channel_0_rsp_bank_id,

   output logic                  u_channel_1_rsp_valid,
   input  logic                  u_channel_1_rsp_ready,
   output logic [RSP_DATA_W-1:0] u_channel_1_rsp_data,
   output logic [BANK_ID_W-1:0]  u_channel_1_rsp_bank_id,

   output logic                  u_channel_2_rsp_valid,
   input  logic                  u_channel_2_rsp_ready,
   output logic [RSP_DATA_W-1:0] u_channel_2_rsp_data,
   output logic [BANK_ID_W-1:0]  u_channel_2_rsp_bank_id
);

   logic [BANK_NUM-1:0]   w_bank_valid;
   logic [BANK_NUM-1:0]   w_bank_ready;
   logic [RSP_DATA_W-1:0] w_bank_data  [BANK_NUM];
   logic [CH_ID_W-1:0]    w_bank_ch_id [BANK_NUM];

   logic [CH_NUM-1:0]     w_ch_ready;
   logic [CH_NUM-1:0]     w_slot_free;
   logic [CH_NUM-1:0]     w_arb_en;
   logic [CH_NUM-1:0]     w_gnt_any;
   logic [BANK_NUM-1:0]   w_req [CH_NUM];
   logic [BANK_NUM-1:0]   w_gnt [CH_NUM];
   rtn_rsp_t              w_rsp_nxt [CH_NUM];

   logic [CH_NUM-1:0]     r_valid;
   rtn_rsp_t              r_rsp [CH_NUM];

   assign w_bank_valid = {d_bank_3_rsp_valid, d_bank_2_rsp_valid,
                          d_bank_1_rsp_valid, d_bank_0_rsp_valid};
   assign w_bank_data[0]  = d_bank_0_rsp_data;
   assign w_bank_data[1]  = d_bank_1_rsp_data;
   assign w_bank_data[2]  = d_bank_2_rsp_data;
   assign w_bank_data[3]  = d_bank_3_rsp_data;
   assign w_bank_ch_id[0] = d_bank_0_rsp_channel_id;
   assign w_bank_ch_id[1] = d_bank_1_rsp_channel_id;
   assign w_bank_ch_id[2] = d_bank_2_rsp_channel_id;
   assign w_bank_ch_id[3] = d_bank_3_rsp_channel_id;

   assign w_ch_ready = {u_channel_2_rsp_ready, u_channel_1_rsp_ready,
                        u_channel_0_rsp_ready};

   // Decode which banks are asking for each channel
   always_comb begin
      for (int m = 0; m < CH_NUM; m++) begin
         w_req[m] = '0;
         for (int n = 0; n < BANK_NUM; n++) begin
            w_req[m][n] = w_bank_valid[n] && (w_bank_ch_id[n] == CH_ID_W'(m));
         end
      end
   end

   // A slot may be reloaded when empty or drained this cycle; reset blocks grants
   always_comb begin
      for (int m = 0; m < CH_NUM; m++) begin
         w_slot_free[m] = !r_valid[m] || w_ch_ready[m];
         w_arb_en[m]    = rst_n && w_slot_free[m];
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_arb
      rr_arb #(
         .N (BANK_NUM)
      ) u_rr_arb (
         .clk   (clk),
         .rst_n (rst_n),
         .i_req (w_req[g]),
         .i_en  (w_arb_en[g]),
         .o_gnt (w_gnt[g])
      );
   end

   // Bank ready: its channel's grant, or immediate accept of an invalid-id beat
   always_comb begin
      w_bank_ready = '0;
      for (int n = 0; n < BANK_NUM; n++) begin
         if (rst_n && w_bank_valid[n] && (w_bank_ch_id[n] == CH_ID_INVALID)) begin
            w_bank_ready[n] = 1'b1;
         end
         for (int m = 0; m < CH_NUM; m++) begin
            if (w_gnt[m][n]) w_bank_ready[n] = 1'b1;
         end
      end
   end

   // Select the granted bank's payload for each channel slot
   always_comb begin
      for (int m = 0; m < CH_NUM; m++) begin
         w_gnt_any[m]         = |w_gnt[m];
         w_rsp_nxt[m].bank_id = onehot_to_idx(w_gnt[m]);
         w_rsp_nxt[m].data    = w_bank_data[w_rsp_nxt[m].bank_id];
      end
   end

   // Output slots: hold under backpressure, load on grant, empty otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int m = 0; m < CH_NUM; m++) begin
            r_rsp[m] <= '0;
         end
      end else begin
         for (int m = 0; m < CH_NUM; m++) begin
            if (w_slot_free[m]) begin
               r_valid[m] <= w_gnt_any[m];
               if (w_gnt_any[m]) r_rsp[m] <= w_rsp_nxt[m];
            end
         end
      end
   end

   assign d_bank_0_rsp_ready = w_bank_ready[0];
   assign d_bank_1_rsp_ready = w_bank_ready[1];
   assign d_bank_2_rsp_ready = w_bank_ready[2];
   assign d_bank_3_rsp_ready = w_bank_ready[3];

   assign u_channel_0_rsp_valid   = r_valid[0];
   assign u_channel_0_rsp_data    = r_rsp[0].data;
   assign u_channel_0_rsp_bank_id = r_rsp[0].bank_id;
   assign u_channel_1_rsp_valid   = r_valid[1];
   assign u_channel_1_rsp_data    = r_rsp[1].data;
   assign u_channel_1_rsp_bank_id = r_rsp[1].bank_id;
   assign u_channel_2_rsp_valid   = r_valid[2];
   assign u_channel_2_rsp_data    = r_rsp[2].data;
   assign u_channel_2_rsp_bank_id = r_rsp[2].bank_id;

endmodule

// File: tb/tb_rtn_xbar_core_4x3.sv
// Self-checking bench for the 4x3 return-path crossbar.
module tb_rtn_xbar_core_4x3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   b_valid;
   logic [3:0]   b_ready;
   logic [127:0] b_data [4];
   logic [1:0]   b_id   [4];
   logic [2:0]   c_valid;
   logic [2:0]   c_ready;
   logic [127:0] c_data [3];
   logic [1:0]   c_bid  [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rtn_xbar_core_4x3 dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .d_bank_0_rsp_valid      (b_valid[0]),
      .d_bank_0_rsp_ready      (b_ready[0]),
      .d_bank_0_rsp_data       (b_data[0]),
      .d_bank_0_rsp_channel_id (b_id[0]),
      .d_bank_1_rsp_valid      (b_valid[1]),
      .d_bank_1_rsp_ready      (b_ready[1]),
      .d_bank_1_rsp_data       (b_data[1]),
      .d_bank_1_rsp_channel_id (b_id[1]),
      .d_bank_2_rsp_valid      (b_valid[2]),
      .d_bank_2_rsp_ready      (b_ready[2]),
      .d_bank_2_rsp_data       (b_data[2]),
      .d_bank_2_rsp_channel_id (b_id[2]),
      .d_bank_3_rsp_valid      (b_valid[3]),
      .d_bank_3_rsp_ready      (b_ready[3]),
      .d_bank_3_rsp_data       (b_data[3]),
      .d_bank_3_rsp_channel_id (b_id[3]),
      .u_channel_0_rsp_valid   (c_valid[0]),
      .u_channel_0_rsp_ready   (c_ready[0]),
      .u_channel_0_rsp_data    (c_data[0]),
      .u_channel_0_rsp_bank_id (c_bid[0]),
      .u_channel_1_rsp_valid   (c_valid[1]),
      .u_channel_1_rsp_ready   (c_ready[1]),
      .u_channel_1_rsp_data    (c_data[1]),
      .u_channel_1_rsp_bank_id (c_bid[1]),
      .u_channel_2_rsp_valid   (c_valid[2]),
      .u_channel_2_rsp_ready   (c_ready[2]),
      .u_channel_2_rsp_data    (c_data[2]),
      .u_channel_2_rsp_bank_id (c_bid[2])
   );

   typedef struct packed {
      logic [3:0] valid;     // bank valids
      logic [7:0] ids;       // {id3,id2,id1,id0}
      logic [2:0] rdy;       // channel readys
      logic [3:0] exp_brdy;  // bank readys in the same cycle
      logic [2:0] exp_vld;   // channel valids after the edge
      logic [5:0] exp_bid;   // {bid2,bid1,bid0} after the edge
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   function automatic logic [127:0] bank_data(input int b);
      logic [7:0] t;
      t = 8'hC0 + 8'(b);
      return {16{t}};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [7:0] ids, input logic [2:0] rdy);
      b_valid = v;
      for (int n = 0; n < 4; n++) b_id[n] = ids[2*n +: 2];
      c_ready = rdy;
   endtask

   task automatic restore_data();
      for (int n = 0; n < 4; n++) b_data[n] = bank_data(n);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      drive(4'b0000, 8'h00, 3'b111);
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      restore_data();
      drive(4'b0000, 8'h00, 3'b111);

      vecs[0]  = '{4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00};
      vecs[1]  = '{4'b0111, 8'b00_01_00_10, 3'b111, 4'b0111, 3'b111, 6'b00_10_01};
      vecs[2]  = '{4'b1000, 8'b11_00_00_00, 3'b111, 4'b1000, 3'b000, 6'b00_00_00};
      vecs[3]  = '{4'b1111, 8'b00_00_00_00, 3'b111, 4'b0100, 3'b001, 6'b00_00_10};
      vecs[4]  = '{4'b1111, 8'b00_00_00_00, 3'b111, 4'b1000, 3'b001, 6'b00_00_11};
      vecs[5]  = '{4'b1111, 8'b00_00_00_00, 3'b111, 4'b0001, 3'b001, 6'b00_00_00};
      vecs[6]  = '{4'b1111, 8'b00_00_00_00, 3'b111, 4'b0010, 3'b001, 6'b00_00_01};
      vecs[7]  = '{4'b1111, 8'b00_00_00_00, 3'b110, 4'b0000, 3'b001, 6'b00_00_01};
      vecs[8]  = '{4'b1111, 8'b00_00_00_00, 3'b110, 4'b0000, 3'b001, 6'b00_00_01};
      vecs[9]  = '{4'b1111, 8'b00_00_00_00, 3'b111, 4'b0100, 3'b001, 6'b00_00_10};
      vecs[10] = '{4'b1011, 8'b01_00_01_10, 3'b111, 4'b1001, 3'b110, 6'b00_11_00};
      vecs[11] = '{4'b1011, 8'b01_00_01_10, 3'b111, 4'b0011, 3'b110, 6'b00_01_00};
      vecs[12] = '{4'b1011, 8'b01_00_01_10, 3'b011, 4'b1000, 3'b110, 6'b00_11_00};
      vecs[13] = '{4'b0000, 8'b00_00_00_00, 3'b011, 4'b0000, 3'b100, 6'b00_00_00};
      vecs[14] = '{4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00};

      // Reset: banks assert valid but must see ready=0, slots cleared
      @(negedge clk);
      drive(4'b1111, 8'h00, 3'b111);
      @(posedge clk);
      @(negedge clk);
      chk("rst_bank_ready", 128'(b_ready), 128'h0);
      @(posedge clk); #1;
      chk("rst_ch_valid", 128'(c_valid), 128'h0);
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("rst_ch%0d_data", m), c_data[m], 128'h0);
         chk($sformatf("rst_ch%0d_bid", m), 128'(c_bid[m]), 128'h0);
      end
      @(negedge clk);
      drive(4'b0000, 8'h00, 3'b111);
      rst_n = 1'b1;

      // Single path: bank 2 -> channel 1 with payload 0xA5
      @(negedge clk);
      b_data[2] = 128'hA5;
      drive(4'b0100, 8'b00_01_00_00, 3'b111);
      #1 chk("single_bank_ready", 128'(b_ready), 128'h4);
      @(posedge clk); #1;
      chk("single_ch_valid", 128'(c_valid), 128'h2);
      chk("single_ch1_data", c_data[1], 128'hA5);
      chk("single_ch1_bid", 128'(c_bid[1]), 128'h2);
      @(negedge clk);
      restore_data();
      drive(4'b0000, 8'h00, 3'b111);

      // Table-driven vectors (pointer state carries from one row to the next)
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].ids, vecs[i].rdy);
         #1 chk($sformatf("vec%0d_bank_ready", i), 128'(b_ready), 128'(vecs[i].exp_brdy));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_ch_valid", i), 128'(c_valid), 128'(vecs[i].exp_vld));
         for (int m = 0; m < 3; m++) begin
            if (vecs[i].exp_vld[m]) begin
               chk($sformatf("vec%0d_ch%0d_bid", i, m), 128'(c_bid[m]),
                   128'(vecs[i].exp_bid[2*m +: 2]));
               chk($sformatf("vec%0d_ch%0d_data", i, m), c_data[m],
                   bank_data(int'(vecs[i].exp_bid[2*m +: 2])));
            end
         end
      end

      // Contention from reset: all banks to channel 0 -> 0,1,2,3,0
      do_reset(1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(4'b1111, 8'h00, 3'b111);
         #1 chk($sformatf("cont%0d_bank_ready", k), 128'(b_ready), 128'(4'b0001 << (k % 4)));
         @(posedge clk); #1;
         chk($sformatf("cont%0d_ch_valid", k), 128'(c_valid), 128'h1);
         chk($sformatf("cont%0d_ch0_bid", k), 128'(c_bid[0]), 128'(k % 4));
      end
      @(negedge clk);
      drive(4'b0000, 8'h00, 3'b111);
      @(posedge clk);

      // Backpressure on channel 1: hold bank 0's beat, bank 2 waits
      @(negedge clk);
      drive(4'b0001, 8'b00_00_00_01, 3'b101);
      #1 chk("bp_load_bank_ready", 128'(b_ready), 128'h1);
      @(posedge clk); #1;
      chk("bp_load_ch_valid", 128'(c_valid), 128'h2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(4'b0100, 8'b00_01_00_00, 3'b101);
         #1 chk($sformatf("bp%0d_bank_ready", k), 128'(b_ready), 128'h0);
         @(posedge clk); #1;
         chk($sformatf("bp%0d_ch_valid", k), 128'(c_valid), 128'h2);
         chk($sformatf("bp%0d_ch1_bid", k), 128'(c_bid[1]), 128'h0);
         chk($sformatf("bp%0d_ch1_data", k), c_data[1], bank_data(0));
      end
      @(negedge clk);
      drive(4'b0100, 8'b00_01_00_00, 3'b111);
      #1 chk("bp_release_bank_ready", 128'(b_ready), 128'h4);
      @(posedge clk); #1;
      chk("bp_release_ch_valid", 128'(c_valid), 128'h2);
      chk("bp_release_ch1_bid", 128'(c_bid[1]), 128'h2);
      chk("bp_release_ch1_data", c_data[1], bank_data(2));

      // Reset mid-stream with random traffic
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive(4'($urandom), 8'($urandom), 3'($urandom));
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         drive(4'b1111, 8'($urandom), 3'($urandom));
         #1 chk($sformatf("mid_rst%0d_bank_ready", k), 128'(b_ready), 128'h0);
         @(posedge clk); #1;
         chk($sformatf("mid_rst%0d_ch_valid", k), 128'(c_valid), 128'h0);
         for (int m = 0; m < 3; m++) begin
            chk($sformatf("mid_rst%0d_ch%0d_bid", k, m), 128'(c_bid[m]), 128'h0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0000, 8'h00, 3'b111);
      @(posedge clk); #1;
      chk("post_rst_ch_valid", 128'(c_valid), 128'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(4'b1111, 8'h00, 3'b111);
         #1 chk($sformatf("post_rst%0d_bank_ready", k), 128'(b_ready), 128'(4'b0001 << k));
         @(posedge clk); #1;
         chk($sformatf("post_rst%0d_ch0_bid", k), 128'(c_bid[0]), 128'(k));
      end

      @(negedge clk);
      drive(4'b0000, 8'h00, 3'b111);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
